// File: rtl/bridge_scheduler.sv
// Downlink/uplink CAN bridge scheduler: downlink FIFO, tx/rx alternation, round-robin rx bus pick.
// Optional per-transaction timeout with abort is built when BRIDGE_SCHED_TIMEOUT_EN is defined.
module bridge_scheduler #(
    parameter int N_BUSES     = 32,
    parameter int MSG_W       = 76,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1000000,
    localparam int BUS_W      = (N_BUSES > 1) ? $clog2(N_BUSES) : 1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tra_valid,
    output logic               tra_ready,
    input  logic [MSG_W-1:0]   tra_data,
    input  logic [BUS_W-1:0]   tra_bus,
    input  logic [N_BUSES-1:0] irq_can_rec,
    output logic [N_BUSES-1:0] rec_ack,
    output logic               start_write,
    output logic               start_read,
    output logic [MSG_W-1:0]   write_data,
    output logic [BUS_W-1:0]   write_bus,
    output logic [BUS_W-1:0]   read_bus,
    input  logic               end_write,
    input  logic               end_read,
    output logic               abort,
    output logic               timeout_err,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [7:0]         statedeb
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = BUS_W + MSG_W;

    typedef enum logic [7:0] {
        S_IDLE  = 8'h01,
        S_WRITE = 8'h02,
        S_READ  = 8'h03
`ifdef BRIDGE_SCHED_TIMEOUT_EN
        , S_ABORT = 8'h04
`endif
    } state_t;

    state_t             state, next_state;
    logic               go_write, go_read;
    logic               last_write;
    logic [BUS_W-1:0]   rr_ptr;
    logic               rx_found;
    logic [BUS_W-1:0]   rx_bus;

    // Downlink handshake: a message transfers on a rising edge where tra_valid && tra_ready.
    // tra_ready depends only on the FIFO level, never on tra_valid.
    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               push;
    logic [ENT_W-1:0]   head;

    assign tra_ready  = (level < LVL_W'(FIFO_DEPTH));
    assign push       = tra_valid && tra_ready;
    assign head       = mem[rd_ptr];
    assign fifo_level = level;
    assign statedeb   = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tra_bus, tra_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (go_write) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !go_write) level <= level + LVL_W'(1);
            else if (!push && go_write) level <= level - LVL_W'(1);
        end
    end

    // First pending receive bus strictly after rr_ptr, wrapping.
    always_comb begin
        rx_found = 1'b0;
        rx_bus   = '0;
        for (int i = 1; i <= N_BUSES; i++) begin
            if (!rx_found && irq_can_rec[BUS_W'((int'(rr_ptr) + i) % N_BUSES)]) begin
                rx_found = 1'b1;
                rx_bus   = BUS_W'((int'(rr_ptr) + i) % N_BUSES);
            end
        end
    end

`ifdef BRIDGE_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign abort   = (state == S_ABORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (go_write || go_read) tmo_cnt <= '0;
            else if (state == S_WRITE || state == S_READ) tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (next_state == S_ABORT) timeout_err <= 1'b1;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        go_write   = 1'b0;
        go_read    = 1'b0;
        unique case (state)
            S_IDLE: begin
                // On a tie, serve the class not served last so tx and rx alternate.
                if ((level != '0) && (!rx_found || !last_write)) begin
                    next_state = S_WRITE;
                    go_write   = 1'b1;
                end else if (rx_found) begin
                    next_state = S_READ;
                    go_read    = 1'b1;
                end
            end
            S_WRITE: begin
                if (end_write) next_state = S_IDLE;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
                else if (tmo_hit) next_state = S_ABORT;
`endif
            end
            S_READ: begin
                if (end_read) next_state = S_IDLE;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
                else if (tmo_hit) next_state = S_ABORT;
`endif
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            start_write <= 1'b0;
            start_read  <= 1'b0;
            rec_ack     <= '0;
            write_data  <= '0;
            write_bus   <= '0;
            read_bus    <= '0;
            rr_ptr      <= BUS_W'(N_BUSES - 1);
            last_write  <= 1'b0;
        end else begin
            state       <= next_state;
            start_write <= go_write;
            start_read  <= go_read;
            rec_ack     <= (state == S_READ && end_read) ? (N_BUSES'(1) << read_bus) : '0;
            if (go_write) begin
                write_data <= head[MSG_W-1:0];
                write_bus  <= head[ENT_W-1:MSG_W];
            end
            if (go_read) begin
                read_bus <= rx_bus;
                rr_ptr   <= rx_bus;
            end
            // Leaving a transaction by completion or abort records its class.
            if (state == S_WRITE && next_state != S_WRITE) last_write <= 1'b1;
            else if (state == S_READ && next_state != S_READ) last_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bridge_scheduler.sv
// Randomized bench for bridge_scheduler against a queue-based scheduling model.
// Timeout scenarios are exercised when BRIDGE_SCHED_TIMEOUT_EN is defined.
module tb_bridge_scheduler;
    localparam int N_BUSES    = 32;
    localparam int MSG_W      = 76;
    localparam int FIFO_DEPTH = 4;
    localparam int BUS_W      = 5;
    localparam int LVL_W      = 3;
    localparam int N_CYC      = 2500;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
    localparam int TMO        = 16;
    localparam int LONG_WAIT  = 20;
`else
    localparam int TMO        = 1000000;
    localparam int LONG_WAIT  = 6;
`endif
    localparam logic [7:0] PH_IDLE  = 8'h01;
    localparam logic [7:0] PH_WRITE = 8'h02;
    localparam logic [7:0] PH_READ  = 8'h03;
    localparam logic [7:0] PH_ABORT = 8'h04;

    logic               clk, rst;
    logic               tra_valid, tra_ready;
    logic [MSG_W-1:0]   tra_data;
    logic [BUS_W-1:0]   tra_bus;
    logic [N_BUSES-1:0] irq_can_rec, rec_ack;
    logic               start_write, start_read;
    logic [MSG_W-1:0]   write_data;
    logic [BUS_W-1:0]   write_bus, read_bus;
    logic               end_write, end_read;
    logic               abort, timeout_err;
    logic [LVL_W-1:0]   fifo_level;
    logic [7:0]         statedeb;

    bridge_scheduler #(
        .N_BUSES(N_BUSES), .MSG_W(MSG_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .tra_valid(tra_valid), .tra_ready(tra_ready), .tra_data(tra_data), .tra_bus(tra_bus),
        .irq_can_rec(irq_can_rec), .rec_ack(rec_ack),
        .start_write(start_write), .start_read(start_read),
        .write_data(write_data), .write_bus(write_bus), .read_bus(read_bus),
        .end_write(end_write), .end_read(end_read),
        .abort(abort), .timeout_err(timeout_err),
        .fifo_level(fifo_level), .statedeb(statedeb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: expected FIFO contents plus the scheduler's abstract state
    logic [BUS_W+MSG_W-1:0] exp_q[$];
    logic [7:0]         m_phase;
    bit                 m_first, m_last_write, m_terr;
    int                 m_rr, m_cnt, m_wait;
    logic [BUS_W-1:0]   m_wbus, m_rbus;
    logic [MSG_W-1:0]   m_wdata;
    logic [N_BUSES-1:0] m_ack;
    int                 n_vec, n_miss;
    int                 cyc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_phase      = PH_IDLE;
        m_first      = 1'b0;
        m_last_write = 1'b0;
        m_terr       = 1'b0;
        m_rr         = N_BUSES - 1;
        m_cnt        = 0;
        m_wait       = 0;
        m_wbus       = '0;
        m_rbus       = '0;
        m_wdata      = '0;
        m_ack        = '0;
    endtask

    function automatic int pick_wait(input int c);
        if (c / 500 == 0) return 3;
        if (c / 500 == 1) return 2;
        if (c / 500 == 4) return $urandom_range(0, LONG_WAIT);
        return $urandom_range(0, 4);
    endfunction

    task automatic compare();
        check("statedeb",    128'(statedeb),    128'(m_phase));
        check("start_write", 128'(start_write), 128'(m_phase == PH_WRITE && m_first));
        check("start_read",  128'(start_read),  128'(m_phase == PH_READ && m_first));
        check("write_bus",   128'(write_bus),   128'(m_wbus));
        check("write_data",  128'(write_data),  128'(m_wdata));
        check("read_bus",    128'(read_bus),    128'(m_rbus));
        check("rec_ack",     128'(rec_ack),     128'(m_ack));
        check("fifo_level",  128'(fifo_level),  128'(exp_q.size()));
        check("tra_ready",   128'(tra_ready),   128'(exp_q.size() < FIFO_DEPTH));
        check("abort",       128'(abort),       128'(m_phase == PH_ABORT));
        check("timeout_err", 128'(timeout_err), 128'(m_terr));
    endtask

    // driver: all inputs for the coming rising edge, including the CAN responder
    task automatic drive(input int c);
        int seg;
        logic [95:0] rnd;
        seg = c / 500;
        rst = (seg == 3) && ($urandom_range(0, 149) == 0);
        case (seg)
            0:       tra_valid = ($urandom_range(0, 9) < 8);
            1:       tra_valid = 1'b0;
            2:       tra_valid = ($urandom_range(0, 9) < 6);
            default: tra_valid = ($urandom_range(0, 1) == 1);
        endcase
        rnd      = {$urandom(), $urandom(), $urandom()};
        tra_data = rnd[MSG_W-1:0];
        tra_bus  = BUS_W'($urandom_range(0, N_BUSES - 1));
        if (seg == 0) irq_can_rec = '0;
        else if (seg == 1) irq_can_rec = (N_BUSES'(1) << 2) | (N_BUSES'(1) << 7) | (N_BUSES'(1) << 30);
        else if (seg == 2) irq_can_rec = N_BUSES'(1) << 4;
        else if (c % 16 == 0) irq_can_rec = ($urandom_range(0, 3) == 0) ? '0 : N_BUSES'($urandom() & $urandom());
        end_write = 1'b0;
        end_read  = 1'b0;
        if (m_phase == PH_WRITE || m_phase == PH_READ) begin
            if (m_wait == 0) begin
                if (m_phase == PH_WRITE) end_write = 1'b1;
                else end_read = 1'b1;
            end else begin
                m_wait--;
            end
        end
        if (seg >= 3) begin
            if (m_phase != PH_WRITE && $urandom_range(0, 9) == 0) end_write = 1'b1;
            if (m_phase != PH_READ && $urandom_range(0, 9) == 0) end_read = 1'b1;
        end
    endtask

    // reference model: advance one clock using the inputs just driven
    task automatic advance(input int c);
        bit push, found;
        int b;
        logic [BUS_W+MSG_W-1:0] ent, hd;
        if (rst) begin
            model_reset();
            return;
        end
        push    = tra_valid && (exp_q.size() < FIFO_DEPTH);
        ent     = {tra_bus, tra_data};
        m_ack   = '0;
        m_first = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (exp_q.size() > 0 && (irq_can_rec == '0 || !m_last_write)) begin
                    hd      = exp_q.pop_front();
                    m_wbus  = hd[BUS_W+MSG_W-1:MSG_W];
                    m_wdata = hd[MSG_W-1:0];
                    m_phase = PH_WRITE;
                    m_first = 1'b1;
                    m_cnt   = 0;
                    m_wait  = pick_wait(c);
                end else if (irq_can_rec != '0) begin
                    found = 1'b0;
                    for (int i = 1; i <= N_BUSES; i++) begin
                        b = (m_rr + i) % N_BUSES;
                        if (!found && irq_can_rec[b]) begin
                            found  = 1'b1;
                            m_rbus = BUS_W'(b);
                            m_rr   = b;
                        end
                    end
                    m_phase = PH_READ;
                    m_first = 1'b1;
                    m_cnt   = 0;
                    m_wait  = pick_wait(c);
                end
            end
            PH_WRITE: begin
                if (end_write) begin
                    m_phase      = PH_IDLE;
                    m_last_write = 1'b1;
                end
`ifdef BRIDGE_SCHED_TIMEOUT_EN
                else if (m_cnt == TMO - 1) begin
                    m_phase      = PH_ABORT;
                    m_last_write = 1'b1;
                    m_terr       = 1'b1;
                end
`endif
                else m_cnt++;
            end
            PH_READ: begin
                if (end_read) begin
                    m_phase      = PH_IDLE;
                    m_last_write = 1'b0;
                    m_ack        = N_BUSES'(1) << m_rbus;
                end
`ifdef BRIDGE_SCHED_TIMEOUT_EN
                else if (m_cnt == TMO - 1) begin
                    m_phase      = PH_ABORT;
                    m_last_write = 1'b0;
                    m_terr       = 1'b1;
                end
`endif
                else m_cnt++;
            end
            default: m_phase = PH_IDLE;
        endcase
        if (push) exp_q.push_back(ent);
    endtask

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        cyc         = 0;
        rst         = 1'b1;
        tra_valid   = 1'b0;
        tra_data    = '0;
        tra_bus     = '0;
        irq_can_rec = '0;
        end_write   = 1'b0;
        end_read    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (cyc = 0; cyc < N_CYC; cyc++) begin
            compare();
            drive(cyc);
            advance(cyc);
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
